// File: rtl/ddr3_port_arbiter_if.sv
// Bundle of requester-side and MIG app_* signals shared by the four-port DDR3 burst arbiter.
// The arbiter uses the master modport; requesters and the MIG model use the slave modport.
interface ddr3_port_arbiter_if #(
    parameter int unsigned ADDR_W = 28
);
    logic                  init_calib_complete;

    logic [1:0]            wr_req;
    logic [2*ADDR_W-1:0]   wr_addr;
    logic [15:0]           wr_len;
    logic [1:0]            rd_req;
    logic [2*ADDR_W-1:0]   rd_addr;
    logic [15:0]           rd_len;

    logic [1:0]            wr_grant;
    logic [1:0]            rd_grant;
    logic [1:0]            wr_beat;
    logic [1:0]            rd_beat;
    logic [1:0]            wr_done;
    logic [1:0]            rd_done;
    logic                  busy;

    logic                  app_rdy;
    logic                  app_wdf_rdy;
    logic                  app_rd_data_valid;
    logic                  app_en;
    logic                  app_wdf_wren;
    logic                  app_wdf_end;
    logic [2:0]            app_cmd;
    logic [ADDR_W-1:0]     app_addr;

    modport master (
        input  init_calib_complete,
        input  wr_req, wr_addr, wr_len, rd_req, rd_addr, rd_len,
        output wr_grant, rd_grant, wr_beat, rd_beat, wr_done, rd_done, busy,
        input  app_rdy, app_wdf_rdy, app_rd_data_valid,
        output app_en, app_wdf_wren, app_wdf_end, app_cmd, app_addr
    );

    modport slave (
        output init_calib_complete,
        output wr_req, wr_addr, wr_len, rd_req, rd_addr, rd_len,
        input  wr_grant, rd_grant, wr_beat, rd_beat, wr_done, rd_done, busy,
        output app_rdy, app_wdf_rdy, app_rd_data_valid,
        input  app_en, app_wdf_wren, app_wdf_end, app_cmd, app_addr
    );
endinterface

// File: rtl/ddr3_port_arbiter.sv
// Round-robin whole-burst arbiter sharing one MIG app_* port between two write and two read
// requesters; issues commands/strobes and steers returned read beats to the owning port.
module ddr3_port_arbiter #(
    parameter int unsigned ADDR_W    = 28,
    parameter int unsigned ADDR_STEP = 8
) (
    input  logic                ui_clk,
    input  logic                rst_n,
    ddr3_port_arbiter_if.master bus
);
    localparam int unsigned LEN_W = 8;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DONE
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_owner, w_owner_nxt;
    logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
    logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
    logic [LEN_W-1:0]   r_len, w_len_nxt;
    logic [LEN_W-1:0]   r_issued, w_issued_nxt;
    logic [LEN_W-1:0]   r_returned, w_returned_nxt;

    logic [NREQ-1:0]    w_req;
    logic [ADDR_W-1:0]  w_req_addr [NREQ];
    logic [LEN_W-1:0]   w_req_len  [NREQ];
    logic [IDX_W-1:0]   w_win;
    logic               w_any;
    logic               w_go;
    logic [1:0]         w_owner_oh;

    // Requesters flattened into index order wr0, wr1, rd0, rd1
    assign w_req         = {bus.rd_req, bus.wr_req};
    assign w_req_addr[0] = bus.wr_addr[0 +: ADDR_W];
    assign w_req_addr[1] = bus.wr_addr[ADDR_W +: ADDR_W];
    assign w_req_addr[2] = bus.rd_addr[0 +: ADDR_W];
    assign w_req_addr[3] = bus.rd_addr[ADDR_W +: ADDR_W];
    assign w_req_len[0]  = bus.wr_len[0 +: LEN_W];
    assign w_req_len[1]  = bus.wr_len[LEN_W +: LEN_W];
    assign w_req_len[2]  = bus.rd_len[0 +: LEN_W];
    assign w_req_len[3]  = bus.rd_len[LEN_W +: LEN_W];

    assign w_any      = |w_req;
    assign w_owner_oh = 2'b01 << r_owner[0];
    assign bus.app_addr = r_addr;

    // Walk from the lowest priority upward so the last hit is the one closest to r_ptr
    always_comb begin
        w_win = r_ptr;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (w_req[r_ptr + IDX_W'(i)]) begin
                w_win = r_ptr + IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_ptr_nxt        = r_ptr;
        w_addr_nxt       = r_addr;
        w_len_nxt        = r_len;
        w_issued_nxt     = r_issued;
        w_returned_nxt   = r_returned;
        w_go             = 1'b0;
        bus.app_en       = 1'b0;
        bus.app_wdf_wren = 1'b0;
        bus.app_wdf_end  = 1'b0;
        bus.app_cmd      = 3'b000;
        bus.wr_grant     = 2'b00;
        bus.rd_grant     = 2'b00;
        bus.wr_beat      = 2'b00;
        bus.rd_beat      = 2'b00;
        bus.wr_done      = 2'b00;
        bus.rd_done      = 2'b00;
        bus.busy         = (r_state != S_IDLE);

        case (r_state)
            S_IDLE: begin
                if (bus.init_calib_complete && w_any) begin
                    w_owner_nxt    = w_win;
                    w_addr_nxt     = w_req_addr[w_win];
                    w_len_nxt      = w_req_len[w_win];
                    w_issued_nxt   = '0;
                    w_returned_nxt = '0;
                    if (w_req_len[w_win] == '0) begin
                        w_state_nxt = S_DONE;
                    end else if (w_win[1]) begin
                        w_state_nxt = S_READ;
                    end else begin
                        w_state_nxt = S_WRITE;
                    end
                end
            end

            S_WRITE: begin
                bus.wr_grant     = w_owner_oh;
                w_go             = bus.app_rdy & bus.app_wdf_rdy;
                bus.app_en       = w_go;
                bus.app_wdf_wren = w_go;
                bus.app_wdf_end  = w_go;
                bus.wr_beat      = w_go ? w_owner_oh : 2'b00;
                if (w_go) begin
                    w_addr_nxt   = r_addr + ADDR_W'(ADDR_STEP);
                    w_issued_nxt = r_issued + LEN_W'(1);
                    if (r_issued + LEN_W'(1) == r_len) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end

            // Commands and returned data are tracked independently; completion follows data
            S_READ: begin
                bus.rd_grant = w_owner_oh;
                bus.app_cmd  = 3'b001;
                w_go         = bus.app_rdy && (r_issued < r_len);
                bus.app_en   = w_go;
                bus.rd_beat  = bus.app_rd_data_valid ? w_owner_oh : 2'b00;
                if (w_go) begin
                    w_addr_nxt   = r_addr + ADDR_W'(ADDR_STEP);
                    w_issued_nxt = r_issued + LEN_W'(1);
                end
                if (bus.app_rd_data_valid) begin
                    w_returned_nxt = r_returned + LEN_W'(1);
                    if (r_returned + LEN_W'(1) == r_len) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end

            S_DONE: begin
                if (r_owner[1]) begin
                    bus.rd_grant = w_owner_oh;
                    bus.rd_done  = w_owner_oh;
                end else begin
                    bus.wr_grant = w_owner_oh;
                    bus.wr_done  = w_owner_oh;
                end
                w_ptr_nxt   = r_owner + IDX_W'(1);
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_owner    <= '0;
            r_ptr      <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_issued   <= '0;
            r_returned <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_ptr      <= w_ptr_nxt;
            r_addr     <= w_addr_nxt;
            r_len      <= w_len_nxt;
            r_issued   <= w_issued_nxt;
            r_returned <= w_returned_nxt;
        end
    end
endmodule

// File: doc/ddr3_port_arbiter.md
# ddr3_port_arbiter

Four-port burst arbiter that shares the single MIG user (app_*) interface between two write requesters (camera frame store, plate-crop store) and two read requesters (display readout, recognition readout). It sits between the per-port FIFO controllers and the MIG core, in the ui_clk domain. It grants whole bursts round-robin, issues the MIG commands and per-beat strobes, and steers returned read beats back to the owning port.

## Interface
- ADDR_W, 28, MIG app_addr width
- ADDR_STEP, 8, app_addr increment per accepted command (one 256-bit beat, BL8)
- ui_clk  in  1  MIG user clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- init_calib_complete  in  1  MIG calibration done; no grants while low
- wr_req  in  2  per write port: burst pending (level)
- wr_addr  in  2*ADDR_W  per write port start address, port p at [p*ADDR_W +: ADDR_W]
- wr_len  in  16  per write port burst length in beats, port p at [p*8 +: 8]
- rd_req / rd_addr / rd_len  in  2 / 2*ADDR_W / 16  same for read ports
- wr_grant, rd_grant  out  2 each  one-hot owner of current burst
- wr_beat  out  2  write-FIFO read strobe of owning port (== app_wdf_wren, steered)
- rd_beat  out  2  app_rd_data_valid steered to owning read port
- wr_done, rd_done  out  2 each  one-cycle pulse at end of burst
- busy  out  1  high whenever state is not IDLE
- app_rdy, app_wdf_rdy, app_rd_data_valid  in  1 each  MIG handshakes
- app_en, app_wdf_wren, app_wdf_end  out  1 each  MIG strobes
- app_cmd  out  3  000 write, 001 read
- app_addr  out  ADDR_W  command address

## Operation
- Requester index: 0 = wr0, 1 = wr1, 2 = rd0, 3 = rd1. Round-robin pointer ptr (2 bits) names the highest-priority index; search ptr, ptr+1, ... mod 4.
- States: IDLE, WRITE, READ, DONE.
- IDLE: if init_calib_complete and any request → latch winner, its addr into addr counter, its len into beat counter; go WRITE (index 0/1) or READ (2/3). init_calib_complete is sampled only in IDLE.
- len == 0: winner is granted, goes straight to DONE, no MIG commands.
- WRITE: go = app_rdy & app_wdf_rdy. app_en = app_wdf_wren = app_wdf_end = go (combinational). wr_beat[owner] = go. Per go: addr += ADDR_STEP, issued count +1. When issued == len → DONE. Owning write FIFOs are first-word-fall-through; app_wdf_data is muxed outside this block by wr_grant.
- READ: app_en = app_rdy & (issued < len); per accepted command addr += ADDR_STEP, issued +1. rd_beat[owner] = app_rd_data_valid. Returned-beat counter increments on every app_rd_data_valid; when returned == len (including the cycle the last beat arrives) → DONE. Reads return in order, so one outstanding burst at a time needs no tags.
- DONE: one cycle; done[owner] = 1; ptr = winner + 1 mod 4; grants drop; → IDLE.
- Requester deasserting req mid-burst is ignored; the burst completes at the latched len. Addresses wrap modulo 2^ADDR_W; min/max frame wrap is the requester's job.
- app_rd_data_valid outside READ is ignored (rd_beat stays 0).
- app_cmd = 001 while in READ, else 000.

## Timing
- Reset: state IDLE, ptr 0, counters 0, app_addr 0, app_cmd 000, all grants/beats/dones/strobes/busy 0.
- Reset mid-burst: immediate return to reset values; partially issued burst is abandoned.
- req seen in IDLE at edge t → grant, busy, state valid in cycle t+1; first app_en in t+1 if app_rdy (and app_wdf_rdy for writes).
- Burst of N beats with MIG always ready: write occupies N cycles + DONE; done pulse in cycle t+1+N. Inter-burst gap: DONE + IDLE = 2 cycles without MIG strobes.
- app_addr is registered and valid whenever app_en is high; it changes only after an accepted command.
- grant holds stable from entry to WRITE/READ through DONE inclusive.

## Test plan
- wr0 only, addr 0x100, len 4, MIG always ready → app_en 4 consecutive cycles at 0x100/0x108/0x110/0x118, wr_beat=01 each, wr_done[0] one cycle later.
- All four requesting continuously, len 2, from reset → grant order wr0, wr1, rd0, rd1, wr0; each exactly 2 commands.
- rd1 len 3, app_rdy toggling 1/0, valid returned 5 cycles after each command → 3 commands, rd_beat=10 three times, rd_done[1] in last-beat cycle+1.
- Write with app_wdf_rdy low 3 cycles mid-burst → no app_en/app_wdf_wren in stall, address does not advance, total beats still equal len.
- init_calib_complete low with requests pending → busy 0, no app_en; rises → wr0 granted next cycle. len 0 request → done pulse, no app_en.
- rst_n asserted mid-read burst of 8 after 3 beats → all outputs 0 asynchronously; after release, ptr 0 and fresh arbitration.
